// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the timer_ctrl port-mapped controller:
// register offsets, CTRL/CMD/STATUS bit positions and FSM encoding.
package timer_ctrl_pkg;

    localparam logic [2:0] OFS_CTRL    = 3'd0;
    localparam logic [2:0] OFS_LOAD_LO = 3'd1;
    localparam logic [2:0] OFS_LOAD_HI = 3'd2;
    localparam logic [2:0] OFS_CMD     = 3'd3;
    localparam logic [2:0] OFS_STATUS  = 3'd4;
    localparam logic [2:0] OFS_COUNT   = 3'd5;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_PRE_LSB = 2;
    localparam int CTRL_PRE_MSB = 4;
    localparam int CTRL_INT_EN  = 5;

    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;

    localparam int STAT_RUN  = 0;
    localparam int STAT_PEND = 1;
    localparam int STAT_OVR  = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

endpackage

// File: rtl/timer_ctrl_edge.sv
// Registered rising-edge detector for the timer interrupt level.
module timer_ctrl_edge (
    input  logic clk_in,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/timer_ctrl.sv
// PicoBlaze port-mapped timer controller with interrupt handshake.
// Define TIMER_CTRL_COUNT_EN to build the saturating expiration counter.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [7:0]  port_id,
    input  logic        write_strobe,
    input  logic        read_strobe,
    input  logic [7:0]  out_port,
    output logic [7:0]  in_port,
    output logic        interrupt,
    input  logic        interrupt_ack,
    output logic [2:0]  prescaler_conf,
    output logic [15:0] timer_conf,
    output logic        en,
    output logic        go,
    output logic        auto_load,
    input  logic        tmr_int
);

    state_t      state;
    logic [5:0]  ctrl_q;
    logic [7:0]  load_lo;
    logic        pending;
    logic        overrun;
    logic [7:0]  count;
    logic [7:0]  rdata;
    logic [7:0]  ofs_full;
    logic [2:0]  ofs;
    logic        hit;
    logic        rise;
    logic        wr_ctrl, wr_lo, wr_hi, wr_cmd;
    logic        start_cmd, stop_cmd;
    logic        rd_status;
    logic        set_pend;
    logic        running;

    timer_ctrl_edge u_edge (
        .clk_in (clk_in),
        .rst    (rst),
        .sig    (tmr_int),
        .rise   (rise)
    );

    assign ofs_full = port_id - BASE_ADDR;
    assign hit      = (ofs_full[7:3] == 5'd0);
    assign ofs      = ofs_full[2:0];

    assign wr_ctrl   = write_strobe & hit & (ofs == OFS_CTRL);
    assign wr_lo     = write_strobe & hit & (ofs == OFS_LOAD_LO);
    assign wr_hi     = write_strobe & hit & (ofs == OFS_LOAD_HI);
    assign wr_cmd    = write_strobe & hit & (ofs == OFS_CMD);
    assign rd_status = read_strobe & hit & (ofs == OFS_STATUS);

    assign stop_cmd  = wr_cmd & out_port[CMD_STOP];
    assign start_cmd = wr_cmd & out_port[CMD_START] & ~out_port[CMD_STOP];
    assign set_pend  = rise & ctrl_q[CTRL_INT_EN];

    assign running        = (state == ST_RUN);
    assign go             = running;
    assign en             = ctrl_q[CTRL_EN];
    assign auto_load      = ctrl_q[CTRL_AUTO];
    assign prescaler_conf = ctrl_q[CTRL_PRE_MSB:CTRL_PRE_LSB];
    assign interrupt      = pending;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            ctrl_q     <= '0;
            load_lo    <= '0;
            timer_conf <= '0;
        end else begin
            if (wr_ctrl) ctrl_q  <= out_port[5:0];
            if (wr_lo)   load_lo <= out_port;
            if (wr_hi)   timer_conf <= {out_port, load_lo};
        end
    end

    // Any exit condition out of RUN takes precedence over a reload.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_cmd && ctrl_q[CTRL_EN]) state <= ST_RUN;
                end
                ST_RUN: begin
                    if (stop_cmd || (wr_ctrl && !out_port[CTRL_EN]) ||
                        (rise && !ctrl_q[CTRL_AUTO])) begin
                        state <= ST_IDLE;
                    end else if (wr_hi) begin
                        state <= ST_RESTART;
                    end
                end
                ST_RESTART: state <= ST_RUN;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (set_pend) begin
                pending <= 1'b1;
            end else if (interrupt_ack) begin
                pending <= 1'b0;
            end
            if (set_pend && pending && !interrupt_ack) begin
                overrun <= 1'b1;
            end else if (rd_status) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef TIMER_CTRL_COUNT_EN
    logic rd_count;

    assign rd_count = read_strobe & hit & (ofs == OFS_COUNT);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            count <= '0;
        end else if (rise) begin
            if (count != 8'hFF) count <= count + 8'd1;
        end else if (rd_count) begin
            count <= '0;
        end
    end
`else
    assign count = 8'h00;
`endif

    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            case (ofs)
                OFS_CTRL:   rdata = {2'b00, ctrl_q};
                OFS_STATUS: rdata = {5'b00000, overrun, pending, running};
                OFS_COUNT:  rdata = count;
                default:    rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            in_port <= '0;
        end else begin
            in_port <= rdata;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
module tb_timer_ctrl;

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  port_id = 8'h00;
    logic        write_strobe = 1'b0;
    logic        read_strobe = 1'b0;
    logic [7:0]  out_port = 8'h00;
    logic [7:0]  in_port;
    logic        interrupt;
    logic        interrupt_ack = 1'b0;
    logic [2:0]  prescaler_conf;
    logic [15:0] timer_conf;
    logic        en;
    logic        go;
    logic        auto_load;
    logic        tmr_int = 1'b0;

    int checks = 0;
    int failures = 0;

    timer_ctrl dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .port_id        (port_id),
        .write_strobe   (write_strobe),
        .read_strobe    (read_strobe),
        .out_port       (out_port),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .interrupt_ack  (interrupt_ack),
        .prescaler_conf (prescaler_conf),
        .timer_conf     (timer_conf),
        .en             (en),
        .go             (go),
        .auto_load      (auto_load),
        .tmr_int        (tmr_int)
    );

    always #5 clk_in = ~clk_in;

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk_in);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        @(negedge clk_in);
        write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] addr, output logic [7:0] data);
        @(negedge clk_in);
        port_id     = addr;
        read_strobe = 1'b1;
        @(negedge clk_in);
        read_strobe = 1'b0;
        data        = in_port;
    endtask

    task automatic pulse();
        @(negedge clk_in);
        tmr_int = 1'b1;
        @(negedge clk_in);
        tmr_int = 1'b0;
    endtask

    task automatic ack();
        @(negedge clk_in);
        interrupt_ack = 1'b1;
        @(negedge clk_in);
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        checks++;
        if ({in_port, interrupt, prescaler_conf, timer_conf, en, go, auto_load} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs got in=%h int=%b pre=%h conf=%h en=%b go=%b al=%b exp all 0",
                     in_port, interrupt, prescaler_conf, timer_conf, en, go, auto_load);
        end
    endtask

    task automatic test_config_start();
        logic [7:0] d;
        wr(8'h10, 8'h21);
        wr(8'h11, 8'hF0);
        wr(8'h12, 8'hFF);
        checks++;
        if (timer_conf !== 16'hFFF0) begin
            failures++;
            $display("FAIL cfg_timer_conf got=%h exp=fff0", timer_conf);
        end
        checks++;
        if ({en, go, auto_load, prescaler_conf} !== 6'b100_000) begin
            failures++;
            $display("FAIL cfg_ctrl_out got en=%b go=%b al=%b pre=%h exp en=1 go=0 al=0 pre=0",
                     en, go, auto_load, prescaler_conf);
        end
        wr(8'h13, 8'h01);
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL start_go got=%b exp=1", go);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL start_status got=%h exp=01", d);
        end
        rd(8'h10, d);
        checks++;
        if (d !== 8'h21) begin
            failures++;
            $display("FAIL ctrl_readback got=%h exp=21", d);
        end
    endtask

    task automatic test_oneshot();
        logic [7:0] d;
        pulse();
        checks++;
        if ({interrupt, go} !== 2'b10) begin
            failures++;
            $display("FAIL oneshot_edge got int=%b go=%b exp int=1 go=0", interrupt, go);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h02) begin
            failures++;
            $display("FAIL oneshot_status got=%h exp=02", d);
        end
`ifdef TIMER_CTRL_COUNT_EN
        rd(8'h15, d);
        checks++;
        if (d !== 8'h01) begin
            failures++;
            $display("FAIL oneshot_count got=%h exp=01", d);
        end
`endif
        ack();
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_ack got=%b exp=0", interrupt);
        end
    endtask

    task automatic test_autoload();
        logic [7:0] d;
        wr(8'h10, 8'h23);
        wr(8'h13, 8'h01);
        pulse();
        pulse();
        checks++;
        if ({go, auto_load} !== 2'b11) begin
            failures++;
            $display("FAIL autoload_go got go=%b al=%b exp go=1 al=1", go, auto_load);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h07) begin
            failures++;
            $display("FAIL autoload_status1 got=%h exp=07", d);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL autoload_status2 got=%h exp=03", d);
        end
`ifdef TIMER_CTRL_COUNT_EN
        rd(8'h15, d);
        checks++;
        if (d !== 8'h02) begin
            failures++;
            $display("FAIL autoload_count got=%h exp=02", d);
        end
`endif
        ack();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        wr(8'h12, 8'h12);
        checks++;
        if ({go, timer_conf} !== {1'b0, 16'h12F0}) begin
            failures++;
            $display("FAIL reload_gap got go=%b conf=%h exp go=0 conf=12f0", go, timer_conf);
        end
        @(negedge clk_in);
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL reload_resume got=%b exp=1", go);
        end
        pulse();
        @(negedge clk_in);
        tmr_int = 1'b1;
        interrupt_ack = 1'b1;
        @(negedge clk_in);
        tmr_int = 1'b0;
        interrupt_ack = 1'b0;
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("FAIL ack_edge_pending got=%b exp=1", interrupt);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h03) begin
            failures++;
            $display("FAIL ack_edge_status got=%h exp=03", d);
        end
        ack();
    endtask

    task automatic test_stop();
        logic [7:0] d;
        wr(8'h13, 8'h03);
        checks++;
        if (go !== 1'b0) begin
            failures++;
            $display("FAIL stop_go got=%b exp=0", go);
        end
        rd(8'h14, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL stop_status got=%h exp=00", d);
        end
        wr(8'h10, 8'h20);
        wr(8'h13, 8'h01);
        checks++;
        if ({en, go} !== 2'b00) begin
            failures++;
            $display("FAIL start_disabled got en=%b go=%b exp 0 0", en, go);
        end
    endtask

    task automatic test_reset_mid_run();
        wr(8'h10, 8'h3D);
        wr(8'h13, 8'h01);
        checks++;
        if (go !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_go got=%b exp=1", go);
        end
        @(negedge clk_in);
        port_id = 8'h10;
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        checks++;
        if ({in_port, interrupt, prescaler_conf, timer_conf, en, go, auto_load} !== 31'd0) begin
            failures++;
            $display("FAIL mid_run_reset got in=%h int=%b pre=%h conf=%h en=%b go=%b al=%b exp all 0",
                     in_port, interrupt, prescaler_conf, timer_conf, en, go, auto_load);
        end
    endtask

    task automatic test_count();
        logic [7:0] d;
`ifdef TIMER_CTRL_COUNT_EN
        rd(8'h15, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL count_initial got=%h exp=00", d);
        end
        for (int i = 0; i < 300; i++) pulse();
        rd(8'h15, d);
        checks++;
        if (d !== 8'hFF) begin
            failures++;
            $display("FAIL count_saturate got=%h exp=ff", d);
        end
`else
        for (int i = 0; i < 3; i++) pulse();
`endif
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("FAIL int_en_off got=%b exp=0", interrupt);
        end
        rd(8'h15, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL count_cleared got=%h exp=00", d);
        end
        rd(8'h16, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL reserved_read got=%h exp=00", d);
        end
        wr(8'h10, 8'h15);
        rd(8'h40, d);
        checks++;
        if (d !== 8'h00) begin
            failures++;
            $display("FAIL unmapped_read got=%h exp=00", d);
        end
        checks++;
        if ({prescaler_conf, auto_load, en} !== 5'b101_0_1) begin
            failures++;
            $display("FAIL prescaler_map got pre=%h al=%b en=%b exp pre=5 al=0 en=1",
                     prescaler_conf, auto_load, en);
        end
    endtask

    initial begin
        test_reset();
        test_config_start();
        test_oneshot();
        test_autoload();
        test_back_to_back();
        test_stop();
        test_reset_mid_run();
        test_count();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
